// File: rtl/logpixel.sv
// Complex FFT sample -> 8-bit log2-magnitude pixel with frame-latched floor,
// plus output-side bin counter that flags frames of the wrong length.
module logpixel #(
  parameter int IW    = 16,
  parameter int LGFFT = 10
) (
  input  logic              i_clk,
  input  logic              i_areset_n,
  input  logic              i_ce,
  input  logic [2*IW-1:0]   i_sample,
  input  logic              i_sync,
  input  logic [7:0]        i_floor,
  output logic              o_ce,
  output logic [7:0]        o_pixel,
  output logic              o_sync,
  output logic [LGFFT-1:0]  o_bin,
  output logic              o_err
);
  localparam int PW     = 2 * IW;
  localparam int STAGES = 4;
  localparam logic [LGFFT-1:0] BIN_LAST = '1;

  logic [STAGES:1]    vld_pipe_q, vld_pipe_d, sync_pipe_q, sync_pipe_d;
  logic [PW-1:0]      re_sq_q, re_sq_d, im_sq_q, im_sq_d, pwr_q, pwr_d;
  logic [7:0]         floor1_q, floor1_d, floor2_q, floor2_d, floor3_q, floor3_d;
  logic [7:0]         lg_q, lg_d, pixel_q, pixel_d;
  logic [LGFFT-1:0]   bin_q, bin_d;
  logic               err_q, err_d, locked_q, locked_d;

  logic signed [IW-1:0] re_s, im_s;
  logic signed [PW-1:0] re_x, im_x;
  logic [4:0]           msb;
  logic [PW+2:0]        pwr_ext;

  always_comb begin
    vld_pipe_d  = {vld_pipe_q[STAGES-1:1], i_ce};
    sync_pipe_d = {sync_pipe_q[STAGES-1:1], i_ce & i_sync};

    // S1: squares; the floor is captured only on a qualified sync so each
    // sample carries the floor of the frame it belongs to down the pipe.
    re_s = i_sample[PW-1:IW];
    im_s = i_sample[IW-1:0];
    re_x = PW'(re_s);
    im_x = PW'(im_s);
    re_sq_d  = i_ce ? $unsigned(re_x * re_x) : re_sq_q;
    im_sq_d  = i_ce ? $unsigned(im_x * im_x) : im_sq_q;
    floor1_d = (i_ce && i_sync) ? i_floor : floor1_q;

    // S2
    pwr_d    = re_sq_q + im_sq_q;
    floor2_d = floor1_q;

    // S3: exponent is the top set bit, mantissa the three bits beneath it
    msb = 5'd0;
    for (int i = 0; i < PW; i++)
      if (pwr_q[i]) msb = 5'(i);
    pwr_ext  = {pwr_q, 3'b000} >> msb;
    lg_d     = {msb, pwr_ext[2:0]};
    floor3_d = floor2_q;

    // S4: floor subtraction and bin tracking
    pixel_d  = pixel_q;
    bin_d    = bin_q;
    err_d    = 1'b0;
    locked_d = locked_q;
    if (vld_pipe_q[3]) begin
      pixel_d = (lg_q > floor3_q) ? lg_q - floor3_q : 8'd0;
      if (sync_pipe_q[3]) begin
        bin_d    = '0;
        err_d    = locked_q && (bin_q != BIN_LAST);
        locked_d = 1'b1;
      end else begin
        bin_d = bin_q + 1'b1;
        err_d = locked_q && (bin_q == BIN_LAST);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      vld_pipe_q  <= '0;
      sync_pipe_q <= '0;
      re_sq_q     <= '0;
      im_sq_q     <= '0;
      pwr_q       <= '0;
      floor1_q    <= '0;
      floor2_q    <= '0;
      floor3_q    <= '0;
      lg_q        <= '0;
      pixel_q     <= '0;
      bin_q       <= '0;
      err_q       <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      sync_pipe_q <= sync_pipe_d;
      re_sq_q     <= re_sq_d;
      im_sq_q     <= im_sq_d;
      pwr_q       <= pwr_d;
      floor1_q    <= floor1_d;
      floor2_q    <= floor2_d;
      floor3_q    <= floor3_d;
      lg_q        <= lg_d;
      pixel_q     <= pixel_d;
      bin_q       <= bin_d;
      err_q       <= err_d;
      locked_q    <= locked_d;
    end
  end

  assign o_ce    = vld_pipe_q[STAGES];
  assign o_sync  = sync_pipe_q[STAGES];
  assign o_pixel = pixel_q;
  assign o_bin   = bin_q;
  assign o_err   = err_q;

endmodule

// File: doc/logpixel.md
# logpixel

Converts complex FFT output samples into 8-bit log-magnitude pixels, for display in the spectrogram.
- Sits between the FFT core and the false-colour mapper; `o_pixel` drives the mapper's pixel input directly.
- Computes power, a piecewise-linear log2 (1/8-octave steps) and a frame-latched floor subtraction.
- Tracks the bin index within each FFT frame and flags frames of the wrong length.

## Interface
- `IW`, 16: width of each signed input component; legal range 8..16.
- `LGFFT`, 10: log2 of FFT length; sets `o_bin` width and the expected frame length.
- `i_clk`  in  1  system clock; all logic on rising edge.
- `i_areset_n`  in  1  reset, asynchronous and active-low.
- `i_ce`  in  1  input sample valid, one per cycle maximum; no backpressure.
- `i_sample`  in  2*IW  `{real, imag}`, each two's-complement IW bits.
- `i_sync`  in  1  qualified by `i_ce`; marks bin 0 of a frame.
- `i_floor`  in  8  log floor; sampled only at frame start.
- `o_ce`  out  1  output pixel valid.
- `o_pixel`  out  8  log-magnitude pixel.
- `o_sync`  out  1  qualified by `o_ce`; bin 0 of frame.
- `o_bin`  out  LGFFT  bin index of `o_pixel`.
- `o_err`  out  1  one-cycle pulse: frame-length error detected.

## Operation
Four-stage pipeline. It always advances, and a valid bit travels with each stage.

**S1**
- Register `re*re` and `im*im`, each 2*IW-bit unsigned.
- If `i_ce && i_sync`, latch `i_floor` into `floor_q`, tagged to this sample.

**S2**
- `p = re² + im²`, 2*IW bits unsigned; cannot overflow.

**S3**
- `e` = index of the most-significant set bit of `p`, 5 bits.
- `m` = the 3 bits immediately below that bit; positions below bit 0 read as 0.
- `L = {e, m}`, 8 bits.
- `p == 0` gives `L = 0`, the same as `p == 1`.

**S4**
- `o_pixel = (L > floor_q) ? L - floor_q : 0`.
- `floor_q` carried down the pipeline with the sync sample, so a whole frame uses one floor value.

**Bin counter (output side)**
- State `locked` is cleared by reset.
- On `o_ce && o_sync`: `o_bin` = 0.
  - If `locked` and the previous `o_bin` ≠ 2^LGFFT−1, pulse `o_err` that cycle.
  - Then set `locked`.
- On `o_ce && !o_sync`: `o_bin` = previous + 1, wrapping 2^LGFFT−1 → 0.
  - If the wrap occurs while `locked`, pulse `o_err`, because a sync is missing.
- `o_bin` is only meaningful when `o_ce` = 1; it holds otherwise.

## Timing
- Latency: `i_ce` at edge n gives `o_ce` at edge n+4. `o_pixel`, `o_sync` and `o_bin` are aligned with it.
- Full throughput: one sample per cycle, back-to-back, no bubbles inserted.
- Gaps in `i_ce` appear unchanged at the output.
- `i_sample` and `i_sync` are ignored when `i_ce` = 0.
- Until the first sync of a frame, the floor register holds its previous value (0 after reset).
- Reset values: `o_ce` = 0, `o_pixel` = 0, `o_sync` = 0, `o_bin` = 0, `o_err` = 0; all valid bits 0; `floor_q` = 0; `locked` = 0.
- Reset asserted mid-frame: in-flight samples are discarded; no `o_ce` until 4 cycles after the first post-reset `i_ce`.
- No `o_err` on the first sync after reset.
- A sync arriving on consecutive samples (1-bin frame) while `locked` gives an `o_err` pulse on the second.

## Test plan
1. **Log values, floor 0.** Reset, then sync sample `{1,0}` followed by `{16,0}`, `{3,4}`, `{0,0}`.
   - Pixels 0, 64, 36, 0.
   - `o_bin` 0, 1, 2, 3.
   - `o_ce` exactly 4 cycles after each `i_ce`.
2. **Extremes, IW=16.** `{-32768,-32768}` → 248; `{-32768,32767}` → 247; `{32767,0}` → 239.
3. **Floor latching.** Set `i_floor` = 40 at sync, then change it to 200 mid-frame. `{3,4}` → 0 and `{16,0}` → 24 for the rest of the frame; the next sync applies 200.
4. **Frame length, LGFFT=3.**
   - Frames of exactly 8 samples: `o_bin` runs 0..7 repeatedly, `o_err` never asserts.
   - A 5-sample frame followed by sync: one `o_err` pulse, coincident with that sync's `o_ce`.
   - 9 samples without sync: `o_err` pulse at the wrap.
5. **Throughput and gaps.** Random `i_ce` pattern over 1000 cycles against a reference model. The output valid pattern equals the input pattern delayed 4, and every pixel matches.
6. **Reset mid-operation.** Assert `i_areset_n` low asynchronously between edges with 3 samples in flight.
   - All outputs go to 0 immediately.
   - After release: no stale `o_ce`, `locked` is clear, and the first sync gives no `o_err`.
